// File: rtl/sc_xbar_tgt_resp.sv
// Target-side responder: register memory, fixed-latency response pipeline and a
// credit-protected FWFT response FIFO. Define SC_RESP_ERR_EN to reserve the top two words.
module sc_xbar_tgt_resp #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int ID_W       = 2,
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic [ID_W-1:0]   i_req_id,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [ID_W-1:0]   o_rsp_id,
  output logic              o_rsp_we,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = $clog2(FIFO_DEPTH + LAT + 1);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic              we;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

  logic              rdy_en_q, rdy_en_d;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] mem_d [MEM_DEPTH];
  logic [LAT-1:0]    pipe_vld_q, pipe_vld_d;
  rsp_t              pipe_ent_q [LAT];
  rsp_t              pipe_ent_d [LAT];
  rsp_t              fifo_q [FIFO_DEPTH];
  rsp_t              fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W:0]    credit;
  logic              accept;
  logic              push;
  logic              pop;
  logic              req_rsv;
  rsp_t              req_ent;
  rsp_t              head;

`ifdef SC_RESP_ERR_EN
  localparam logic [ADDR_W-1:0] RSV_BASE = ADDR_W'(MEM_DEPTH - 2);
  assign req_rsv = (i_req_addr >= RSV_BASE);
`else
  assign req_rsv = 1'b0;
`endif

  // Credits cover every accepted request not yet popped; a same-cycle pop frees one.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + CNT_W'(pipe_vld_q[i]);
    end
  end

  assign head        = fifo_q[rd_ptr_q];
  assign o_rsp_valid = (fifo_cnt_q != '0);
  assign pop         = o_rsp_valid & i_rsp_ready;
  assign credit      = (CNT_W+1)'(FIFO_DEPTH) + (CNT_W+1)'(pop)
                     - (CNT_W+1)'(fifo_cnt_q) - (CNT_W+1)'(inflight);
  assign o_req_ready = rdy_en_q & (credit != '0);
  assign accept      = i_req_valid & o_req_ready;
  assign push        = pipe_vld_q[LAT-1];

  assign o_rsp_id    = o_rsp_valid ? head.id    : '0;
  assign o_rsp_we    = o_rsp_valid ? head.we    : 1'b0;
  assign o_rsp_rdata = o_rsp_valid ? head.rdata : '0;
  assign o_rsp_err   = o_rsp_valid ? head.err   : 1'b0;

  // Request stage: memory read/write on the accept edge.
  always_comb begin
    req_ent.id    = i_req_id;
    req_ent.we    = i_req_we;
    req_ent.rdata = (i_req_we | req_rsv) ? '0 : mem_q[i_req_addr];
    req_ent.err   = req_rsv;
    mem_d = mem_q;
    if (accept && i_req_we && !req_rsv) begin
      mem_d[i_req_addr] = i_req_wdata;
    end
  end

  // Latency pipeline: fixed shift, never stalls.
  always_comb begin
    pipe_vld_d[0] = accept;
    pipe_ent_d[0] = req_ent;
    for (int i = 1; i < LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_ent_d[i] = pipe_ent_q[i-1];
    end
  end

  // Response FIFO: push from the last pipeline stage, first-word-fall-through pop.
  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      fifo_d[wr_ptr_q] = pipe_ent_q[LAT-1];
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  assign rdy_en_d = 1'b1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rdy_en_q   <= 1'b0;
      pipe_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      mem_q      <= '{default: '0};
    end else begin
      rdy_en_q   <= rdy_en_d;
      pipe_vld_q <= pipe_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      mem_q      <= mem_d;
    end
  end

  // Payload storage is qualified by the valid/count state, so it needs no reset.
  always_ff @(posedge i_clk) begin
    pipe_ent_q <= pipe_ent_d;
    fifo_q     <= fifo_d;
  end

endmodule

// File: tb/tb_sc_xbar_tgt_resp.sv
// Bench for sc_xbar_tgt_resp: directed steps plus random traffic against a
// transaction-level model (outstanding-response queue with visibility times).
module tb_sc_xbar_tgt_resp;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 4;
  localparam int ID_W       = 2;
  localparam int LAT        = 2;
  localparam int FIFO_DEPTH = 4;
`ifdef SC_RESP_ERR_EN
  localparam bit ERR_BUILD = 1'b1;
`else
  localparam bit ERR_BUILD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              i_reset;
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic [ADDR_W-1:0] i_req_addr;
  logic [DATA_W-1:0] i_req_wdata;
  logic [ID_W-1:0]   i_req_id;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [ID_W-1:0]   o_rsp_id;
  logic              o_rsp_we;
  logic [DATA_W-1:0] o_rsp_rdata;
  logic              o_rsp_err;

  always #5 clk = ~clk;

  sc_xbar_tgt_resp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_id(i_req_id),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_id(o_rsp_id),
    .o_rsp_we(o_rsp_we), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err)
  );

  typedef struct {
    logic [ID_W-1:0]   id;
    logic              we;
    logic [DATA_W-1:0] rdata;
    logic              err;
    int                vis;
  } exp_t;

  int                checks  = 0;
  int                errors  = 0;
  int                cyc     = 0;
  int                acc_obs = 0;
  int                pop_obs = 0;
  bit                armed   = 1'b0;
  logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
  exp_t              q[$];

  function automatic bit is_rsv(input logic [ADDR_W-1:0] a);
    return ERR_BUILD && (a >= ADDR_W'((1 << ADDR_W) - 2));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    foreach (ref_mem[i]) ref_mem[i] = '0;
    armed = 1'b0;
  endtask

  task automatic set_req(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [ID_W-1:0] id);
    i_req_valid = v;
    i_req_we    = we;
    i_req_addr  = a;
    i_req_wdata = d;
    i_req_id    = id;
  endtask

  // One clock: check outputs on the falling edge, advance the model on the rising edge.
  task automatic step();
    bit                ev, er, acc, pop;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic [ID_W-1:0]   id;
    exp_t              e;
    @(negedge clk);
    ev = (q.size() > 0) && (q[0].vis <= cyc);
    er = armed && (q.size() < FIFO_DEPTH + int'(ev && i_rsp_ready));
    chk("req_ready", 64'(o_req_ready), 64'(er));
    chk("rsp_valid", 64'(o_rsp_valid), 64'(ev));
    if (ev) begin
      chk("rsp_id",    64'(o_rsp_id),    64'(q[0].id));
      chk("rsp_we",    64'(o_rsp_we),    64'(q[0].we));
      chk("rsp_rdata", 64'(o_rsp_rdata), 64'(q[0].rdata));
      chk("rsp_err",   64'(o_rsp_err),   64'(q[0].err));
    end
    if (o_req_ready && i_req_valid) acc_obs++;
    if (o_rsp_valid && i_rsp_ready) pop_obs++;
    acc = er && i_req_valid;
    pop = ev && i_rsp_ready;
    we = i_req_we; a = i_req_addr; wd = i_req_wdata; id = i_req_id;
    @(posedge clk);
    cyc++;
    if (pop) void'(q.pop_front());
    if (acc) begin
      e.id    = id;
      e.we    = we;
      e.err   = is_rsv(a);
      e.rdata = (we || e.err) ? '0 : ref_mem[a];
      e.vis   = cyc + LAT;
      q.push_back(e);
      if (we && !e.err) ref_mem[a] = wd;
    end
    armed = !i_reset;
    #1;
  endtask

  task automatic idle_steps(input int n);
    set_req(1'b0, 1'b0, '0, '0, '0);
    repeat (n) step();
  endtask

  initial begin
    int a0, p0;
    i_reset = 1'b1;
    i_rsp_ready = 1'b1;
    set_req(1'b0, 1'b0, '0, '0, '0);
    model_reset();

    // Reset hold and release
    repeat (10) step();
    chk("rst_rsp_id",    64'(o_rsp_id),    64'(0));
    chk("rst_rsp_rdata", 64'(o_rsp_rdata), 64'(0));
    chk("rst_rsp_err",   64'(o_rsp_err),   64'(0));
    i_reset = 1'b0;
    step();
    chk("rst_ready_after", 64'(o_req_ready), 64'(1));
    set_req(1'b1, 1'b0, 4'd5, '0, 2'd0);
    step();
    idle_steps(LAT + 2);

    // Write then read-after-write
    set_req(1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF, 2'd1);
    step();
    set_req(1'b1, 1'b0, 4'd3, '0, 2'd2);
    step();
    idle_steps(LAT + 3);

    // Backpressure
    i_rsp_ready = 1'b0;
    a0 = acc_obs;
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, 1'b0, ADDR_W'(i), '0, ID_W'(i));
      step();
    end
    chk("bp_accepts", 64'(acc_obs - a0), 64'(FIFO_DEPTH));
    chk("bp_ready_low", 64'(o_req_ready), 64'(0));
    idle_steps(3);
    p0 = pop_obs;
    i_rsp_ready = 1'b1;
    idle_steps(FIFO_DEPTH + 4);
    chk("bp_pops", 64'(pop_obs - p0), 64'(FIFO_DEPTH));
    chk("bp_ready_back", 64'(o_req_ready), 64'(1));

    // Full-rate stream
    a0 = acc_obs;
    p0 = pop_obs;
    for (int i = 0; i < 100; i++) begin
      set_req(1'b1, 1'($urandom), ADDR_W'(i % 16), $urandom, ID_W'($urandom));
      step();
    end
    chk("fr_accepts", 64'(acc_obs - a0), 64'(100));
    idle_steps(LAT + 3);
    chk("fr_pops", 64'(pop_obs - p0), 64'(100));

    // Reset with responses queued
    set_req(1'b1, 1'b1, 4'd7, 32'hA5A5_0007, 2'd3);
    step();
    idle_steps(LAT + 3);
    i_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 1'b0, 4'd7, '0, ID_W'(i));
      step();
    end
    idle_steps(LAT + 1);
    chk("mid_valid_before", 64'(o_rsp_valid), 64'(1));
    #2 i_reset = 1'b1;
    #1;
    chk("mid_async_valid", 64'(o_rsp_valid), 64'(0));
    chk("mid_async_ready", 64'(o_req_ready), 64'(0));
    chk("mid_async_id",    64'(o_rsp_id),    64'(0));
    model_reset();
    idle_steps(3);
    i_reset = 1'b0;
    i_rsp_ready = 1'b1;
    idle_steps(4);
    set_req(1'b1, 1'b0, 4'd7, '0, 2'd1);
    step();
    set_req(1'b1, 1'b0, 4'd3, '0, 2'd2);
    step();
    idle_steps(LAT + 3);

    // Reserved-address behaviour (plain memory when the feature is compiled out)
    set_req(1'b1, 1'b1, 4'd15, 32'h0000_1234, 2'd1);
    step();
    set_req(1'b1, 1'b0, 4'd15, '0, 2'd2);
    step();
    set_req(1'b1, 1'b0, 4'd13, '0, 2'd3);
    step();
    idle_steps(LAT + 4);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      set_req(1'($urandom_range(0, 3) != 0), 1'($urandom), ADDR_W'($urandom_range(0, 15)),
              $urandom, ID_W'($urandom));
      i_rsp_ready = 1'($urandom_range(0, 3) != 0);
      step();
    end
    i_rsp_ready = 1'b1;
    idle_steps(FIFO_DEPTH + LAT + 4);
    chk("final_empty", 64'(o_rsp_valid), 64'(0));
    chk("final_ready", 64'(o_req_ready), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sc_xbar_tgt_resp.md
Name: sc_xbar_tgt_resp

Overview:
- Target-side responder for the round-robin crossbar in sc_sys_core.
- Sits at a crossbar output port and accepts routed requests (read/write, tagged with source ID).
- Services requests from a local register memory.
- Returns tagged responses, after a fixed pipeline latency and through a credit-protected response FIFO, which the crossbar routes back to the originating initiator.

Parameters:
- DATA_W, 32, data width of request write data and response read data.
- ADDR_W, 4, word address width; memory depth is 2**ADDR_W words.
- ID_W, 2, source-ID tag width, echoed unchanged in the response.
- LAT, 2, cycles from request acceptance to earliest response valid; legal range 1..4.
- FIFO_DEPTH, 4, response FIFO entries; power of two, >= 2.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  request valid from crossbar.
- o_req_ready  out  1  responder can accept a request this cycle.
- i_req_we  in  1  1 = write, 0 = read.
- i_req_addr  in  ADDR_W  word address.
- i_req_wdata  in  DATA_W  write data.
- i_req_id  in  ID_W  source initiator ID.
- o_rsp_valid  out  1  response valid toward crossbar.
- i_rsp_ready  in  1  crossbar accepts the response.
- o_rsp_id  out  ID_W  echoed source ID.
- o_rsp_we  out  1  echoed request type.
- o_rsp_rdata  out  DATA_W  read data; 0 for write responses.
- o_rsp_err  out  1  error flag; see Optional Feature. Tied 0 when the feature is compiled out.

Behaviour:
- Reset (async assert, sync release): o_req_ready=0 during reset and 1 from the first clock after release. All o_rsp_* = 0. FIFO empty, pipeline empty, all memory words 0.
- Request handshake: accept = i_req_valid & o_req_ready; request fields are sampled on that edge. i_req_valid with o_req_ready=0 is ignored and has no side effects.
- Write: memory[addr] <= wdata on the accept edge.
- Read: data is sampled on the accept edge. A read accepted the cycle after a write to the same address returns the new data. A same-cycle write cannot occur (single port).
- Pipeline: LAT-stage shift of {valid, id, we, rdata, err}. The stage-LAT output is pushed into the response FIFO. The pipeline never stalls.
- Credits: credit = FIFO_DEPTH - fifo_count - inflight, where inflight = number of valid pipeline stages. o_req_ready = (credit != 0). Counters are sized to hold 0..FIFO_DEPTH+LAT.
- Simultaneous accept and FIFO pop: the pop frees a credit in the same cycle (credit counts the pop combinationally), so a full-rate stream with i_rsp_ready=1 sustains 1 request/cycle.
- Latency: with the FIFO empty, o_rsp_valid rises exactly LAT cycles after the accept edge. The FIFO output is first-word-fall-through: the pushed entry is visible on the push-cycle's following edge.
- Response handshake: pop on o_rsp_valid & i_rsp_ready. While o_rsp_valid=1 and i_rsp_ready=0, all o_rsp_* stay stable.
- Ordering: responses leave in request-acceptance order; no reordering.
- FIFO full: a push to a full FIFO cannot occur; the credit scheme guarantees this. Bench asserts no overflow or underflow.
- Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH. Count is distinguished full vs empty.
- Reset mid-operation: in-flight requests and queued responses are discarded with no response emitted. Memory contents return to 0.

Optional Feature:
- Macro SC_RESP_ERR_EN.
- Defined:
  - Addresses >= 2**ADDR_W - 2 (top two words) are reserved.
  - An access to a reserved address does not modify memory, returns rdata=0, and sets o_rsp_err=1 in that response.
  - Latency and ordering are unchanged.
- Undefined:
  - All addresses are valid memory.
  - o_rsp_err is constant 0.

Test Plan:
- Reset: i_reset held 10 cycles then released -> o_req_ready=1 on next edge, o_rsp_valid=0, read of addr 5 returns rdata=0x0000_0000.
- Write/read: write addr 3 = 0xDEAD_BEEF id 1, next cycle read addr 3 id 2 -> responses in order {id1, we=1, rdata 0} then {id2, we=0, rdata 0xDEAD_BEEF}, first valid exactly LAT=2 cycles after accept.
- Backpressure: i_rsp_ready=0, stream 8 reads -> exactly FIFO_DEPTH=4 accepted, o_req_ready=0 afterward, o_rsp_* stable. Then i_rsp_ready=1 -> 4 responses in order, ready returns, no overflow.
- Full rate: i_req_valid=1 and i_rsp_ready=1 for 100 cycles with addresses 0..15 wrapping -> 100 accepts in 100 cycles, 100 responses in order.
- Mid-op reset: assert i_reset with 3 responses queued -> o_rsp_valid=0 immediately (async). After release no stale responses appear and memory reads 0.
- SC_RESP_ERR_EN: write 0x1234 to addr 15 then read addr 15 -> both responses o_rsp_err=1, rdata=0. A read of addr 13 returns o_rsp_err=0.
